// File: rtl/music_pkg.sv
// Shared note/octave codes, mid-octave half-period counts and tone FSM states.
// Pure definitions: no latency, no backpressure.
package music_pkg;

    localparam logic [1:0] OCT_REST = 2'b00;
    localparam logic [1:0] OCT_LOW  = 2'b01;
    localparam logic [1:0] OCT_HIGH = 2'b10;
    localparam logic [1:0] OCT_MID  = 2'b11;

    localparam logic [2:0] NOTE_REST = 3'd0;
    localparam logic [2:0] NOTE_DO   = 3'd1;
    localparam logic [2:0] NOTE_RE   = 3'd2;
    localparam logic [2:0] NOTE_MI   = 3'd3;
    localparam logic [2:0] NOTE_FA   = 3'd4;
    localparam logic [2:0] NOTE_SOL  = 3'd5;
    localparam logic [2:0] NOTE_LA   = 3'd6;
    localparam logic [2:0] NOTE_TI   = 3'd7;

    // Half-period lengths in 50 MHz clocks for the middle octave.
    localparam int unsigned HALF_DO  = 95556;
    localparam int unsigned HALF_RE  = 85131;
    localparam int unsigned HALF_MI  = 75842;
    localparam int unsigned HALF_FA  = 71586;
    localparam int unsigned HALF_SOL = 63776;
    localparam int unsigned HALF_LA  = 56818;
    localparam int unsigned HALF_TI  = 50619;

    typedef enum logic {
        SILENT = 1'b0,
        TONE   = 1'b1
    } tone_state_t;

    function automatic int unsigned mid_half(input logic [2:0] note);
        case (note)
            NOTE_DO:  return HALF_DO;
            NOTE_RE:  return HALF_RE;
            NOTE_MI:  return HALF_MI;
            NOTE_FA:  return HALF_FA;
            NOTE_SOL: return HALF_SOL;
            NOTE_LA:  return HALF_LA;
            NOTE_TI:  return HALF_TI;
            default:  return 0;
        endcase
    endfunction

endpackage

// File: rtl/note_tone_gen_if.sv
// Note source to tone generator bundle; volume exists only with VOLUME_PWM_EN.
// Plain level signals: no handshake, no backpressure.
interface note_tone_gen_if;
    logic [4:0] note_index;
    logic       speaker;
    logic       note_active;
    logic [4:0] cur_index;
`ifdef VOLUME_PWM_EN
    logic [2:0] volume;

    modport master (output note_index, output volume,
                    input speaker, input note_active, input cur_index);
    modport slave  (input note_index, input volume,
                    output speaker, output note_active, output cur_index);
`else
    modport master (output note_index,
                    input speaker, input note_active, input cur_index);
    modport slave  (input note_index,
                    output speaker, output note_active, output cur_index);
`endif
endinterface

// File: rtl/note_divisor_rom.sv
// Note index -> {is_rest, half-period count}; purely combinational, no backpressure.
module note_divisor_rom
    import music_pkg::*;
#(
    parameter int DIV_W     = 18,
    parameter int OCT_SHIFT = 1
) (
    input  logic [4:0]       index_i,
    output logic             is_rest_o,
    output logic [DIV_W-1:0] half_period_o
);

    logic [1:0]  octave;
    logic [2:0]  note;
    int unsigned mid;

    assign octave = index_i[4:3];
    assign note   = index_i[2:0];

    always_comb begin
        mid           = mid_half(note);
        is_rest_o     = (octave == OCT_REST) || (note == NOTE_REST);
        half_period_o = '0;
        if (!is_rest_o) begin
            case (octave)
                OCT_MID:  half_period_o = DIV_W'(mid);
                OCT_HIGH: half_period_o = DIV_W'(mid >> OCT_SHIFT);
                OCT_LOW:  half_period_o = DIV_W'(mid << OCT_SHIFT);
                default:  half_period_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/note_tone_gen.sv
// Note index -> glitch-free piezo square wave; speaker rises 2 clk after a note appears, no backpressure.
// Optional VOLUME_PWM_EN gates the high phase with a free-running 3-bit PWM.
module note_tone_gen
    import music_pkg::*;
#(
    parameter int DIV_W     = 18,
    parameter int OCT_SHIFT = 1
) (
    input  logic             clk,
    input  logic             reset,
    note_tone_gen_if.slave   bus
);

    tone_state_t       state_q;
    logic [DIV_W-1:0]  cnt_q;
    logic              phase_q;
    logic [4:0]        cur_q;
    logic [4:0]        idx_q;

    logic              rom_rest;
    logic [DIV_W-1:0]  rom_half;
    logic [DIV_W-1:0]  reload;
    logic              gate;

    note_divisor_rom #(
        .DIV_W     (DIV_W),
        .OCT_SHIFT (OCT_SHIFT)
    ) u_rom (
        .index_i       (idx_q),
        .is_rest_o     (rom_rest),
        .half_period_o (rom_half)
    );

    assign reload = rom_half - DIV_W'(1);

    // idx_q is only acted on at half-period boundaries, so mid-period changes never cut a half short.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SILENT;
            cnt_q   <= '0;
            phase_q <= 1'b0;
            cur_q   <= '0;
            idx_q   <= '0;
        end else begin
            idx_q <= bus.note_index;
            case (state_q)
                SILENT: begin
                    if (!rom_rest) begin
                        state_q <= TONE;
                        cnt_q   <= reload;
                        phase_q <= 1'b1;
                        cur_q   <= idx_q;
                    end
                end
                TONE: begin
                    if (cnt_q == '0) begin
                        if (rom_rest) begin
                            state_q <= SILENT;
                            phase_q <= 1'b0;
                            cur_q   <= '0;
                        end else begin
                            cnt_q   <= reload;
                            phase_q <= ~phase_q;
                            cur_q   <= idx_q;
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_W'(1);
                    end
                end
                default: state_q <= SILENT;
            endcase
        end
    end

`ifdef VOLUME_PWM_EN
    logic [2:0] pwm_cnt_q;
    logic [2:0] pwm_cnt_d;

    assign pwm_cnt_d = pwm_cnt_q + 3'd1;

    always_ff @(posedge clk) begin
        if (reset) pwm_cnt_q <= '0;
        else       pwm_cnt_q <= pwm_cnt_d;
    end

    assign gate = (pwm_cnt_q <= bus.volume);
`else
    assign gate = 1'b1;
`endif

    assign bus.speaker     = phase_q & gate;
    assign bus.note_active = (state_q == TONE);
    assign bus.cur_index   = cur_q;

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen: directed timing scenarios plus randomized run against a time-based reference model.
module tb_note_tone_gen;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    note_tone_gen_if tif();

    note_tone_gen #(.DIV_W(18), .OCT_SHIFT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tif)
    );

    logic [4:0]  rom_idx;
    logic        rom_rest;
    logic [17:0] rom_half;

    note_divisor_rom #(.DIV_W(18), .OCT_SHIFT(1)) rom (
        .index_i       (rom_idx),
        .is_rest_o     (rom_rest),
        .half_period_o (rom_half)
    );

    int vectors     = 0;
    int miscompares = 0;

    int mid_tab [8] = '{0, 95556, 85131, 75842, 71586, 63776, 56818, 50619};

    function automatic int half_of(input logic [4:0] idx);
        int m;
        m = mid_tab[idx[2:0]];
        if (idx[2:0] == 3'd0) return 0;
        case (idx[4:3])
            2'b11:   return m;
            2'b10:   return m / 2;
            2'b01:   return m * 2;
            default: return 0;
        endcase
    endfunction

    // Reference: a tone is a sequence of half-periods with absolute end times.
    logic       m_silent = 1'b1;
    logic       m_phase  = 1'b0;
    logic [4:0] m_cur    = 5'd0;
    logic [4:0] m_idxq   = 5'd0;
    logic [2:0] m_pwm    = 3'd0;
    longint     m_cyc    = 0;
    longint     m_end    = 0;

    always @(posedge clk) begin
        logic [4:0] pend;
        int h;
        if (reset) begin
            m_silent = 1'b1;
            m_phase  = 1'b0;
            m_cur    = 5'd0;
            m_idxq   = 5'd0;
            m_pwm    = 3'd0;
        end else begin
            pend = m_idxq;
            h    = half_of(pend);
            if (m_silent) begin
                if (h != 0) begin
                    m_silent = 1'b0;
                    m_phase  = 1'b1;
                    m_cur    = pend;
                    m_end    = m_cyc + h;
                end
            end else if (m_cyc == m_end) begin
                if (h == 0) begin
                    m_silent = 1'b1;
                    m_phase  = 1'b0;
                    m_cur    = 5'd0;
                end else begin
                    m_phase = ~m_phase;
                    m_cur   = pend;
                    m_end   = m_cyc + h;
                end
            end
            m_idxq = tif.note_index;
            m_pwm  = m_pwm + 3'd1;
        end
        m_cyc++;
    end

    task automatic test_reset();
        reset          = 1'b1;
        tif.note_index = 5'd0;
`ifdef VOLUME_PWM_EN
        tif.volume     = 3'd7;
`endif
        repeat (3) @(negedge clk);
        vectors++;
        if (tif.speaker !== 1'b0) begin
            miscompares++; $display("FAIL reset_speaker: got %b expected 0", tif.speaker);
        end
        vectors++;
        if (tif.note_active !== 1'b0) begin
            miscompares++; $display("FAIL reset_note_active: got %b expected 0", tif.note_active);
        end
        vectors++;
        if (tif.cur_index !== 5'd0) begin
            miscompares++; $display("FAIL reset_cur_index: got %b expected 00000", tif.cur_index);
        end
    endtask

    task automatic test_rom_decode();
        for (int i = 0; i < 32; i++) begin
            rom_idx = 5'(i);
            #1;
            vectors++;
            if (rom_rest !== (half_of(5'(i)) == 0)) begin
                miscompares++;
                $display("FAIL rom_rest[%0d]: got %b expected %b", i, rom_rest, half_of(5'(i)) == 0);
            end
            vectors++;
            if (half_of(5'(i)) != 0 && int'(rom_half) != half_of(5'(i))) begin
                miscompares++;
                $display("FAIL rom_half[%0d]: got %0d expected %0d", i, rom_half, half_of(5'(i)));
            end
        end
    endtask

    task automatic test_tone_start();
        @(negedge clk);
        reset          = 1'b0;
        tif.note_index = 5'b11110;
        @(negedge clk);
        vectors++;
        if (tif.speaker !== 1'b0) begin
            miscompares++; $display("FAIL start_1clk_speaker: got %b expected 0", tif.speaker);
        end
        @(negedge clk);
        vectors++;
        if (tif.speaker !== 1'b1) begin
            miscompares++; $display("FAIL start_2clk_speaker: got %b expected 1", tif.speaker);
        end
        vectors++;
        if (tif.note_active !== 1'b1) begin
            miscompares++; $display("FAIL start_note_active: got %b expected 1", tif.note_active);
        end
        vectors++;
        if (tif.cur_index !== 5'b11110) begin
            miscompares++; $display("FAIL start_cur_index: got %b expected 11110", tif.cur_index);
        end
    endtask

    task automatic test_reset_mid_tone();
        repeat (40) @(negedge clk);
        vectors++;
        if (tif.speaker !== 1'b1) begin
            miscompares++; $display("FAIL midtone_speaker: got %b expected 1", tif.speaker);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (tif.speaker !== 1'b0 || tif.note_active !== 1'b0 || tif.cur_index !== 5'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs: got spk=%b act=%b cur=%b expected 0 0 00000",
                     tif.speaker, tif.note_active, tif.cur_index);
        end
        @(negedge clk);
        vectors++;
        if (tif.speaker !== 1'b0) begin
            miscompares++; $display("FAIL restart_1clk_speaker: got %b expected 0", tif.speaker);
        end
        @(negedge clk);
        vectors++;
        if (tif.speaker !== 1'b1 || tif.cur_index !== 5'b11110) begin
            miscompares++;
            $display("FAIL restart_2clk: got spk=%b cur=%b expected 1 11110", tif.speaker, tif.cur_index);
        end
    endtask

    task automatic test_boundary_changes();
        int n;
        int m;
        reset = 1'b1;
        @(negedge clk);
        reset          = 1'b0;
        tif.note_index = 5'b10110;
        repeat (2) @(negedge clk);
        vectors++;
        if (tif.speaker !== 1'b1) begin
            miscompares++; $display("FAIL highA_rise: got %b expected 1", tif.speaker);
        end
        // High A high phase with a brief rest glitch, then a late switch to high B.
        n = 1;
        while (tif.speaker === 1'b1 && n < 30000) begin
            if (n == 1000)  tif.note_index = 5'b11000;
            if (n == 1005)  tif.note_index = 5'b10110;
            if (n == 20000) tif.note_index = 5'b10111;
            if (n == 28408) begin
                vectors++;
                if (tif.cur_index !== 5'b10110) begin
                    miscompares++;
                    $display("FAIL pre_boundary_cur: got %b expected 10110", tif.cur_index);
                end
            end
            @(negedge clk);
            if (tif.speaker === 1'b1) n++;
        end
        vectors++;
        if (n != 28409) begin
            miscompares++; $display("FAIL highA_high_len: got %0d expected 28409", n);
        end
        vectors++;
        if (tif.cur_index !== 5'b10111 || tif.note_active !== 1'b1) begin
            miscompares++;
            $display("FAIL post_boundary: got cur=%b act=%b expected 10111 1", tif.cur_index, tif.note_active);
        end
        m = 1;
        while (tif.note_active === 1'b1 && m < 30000) begin
            if (m == 10000) begin
                tif.note_index = 5'b00000;
                vectors++;
                if (tif.speaker !== 1'b0) begin
                    miscompares++; $display("FAIL highB_low_phase: got %b expected 0", tif.speaker);
                end
            end
            @(negedge clk);
            if (tif.note_active === 1'b1) m++;
        end
        vectors++;
        if (m != 25309) begin
            miscompares++; $display("FAIL highB_low_len: got %0d expected 25309", m);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (tif.speaker !== 1'b0 || tif.note_active !== 1'b0 || tif.cur_index !== 5'd0) begin
            miscompares++;
            $display("FAIL rest_silence: got spk=%b act=%b cur=%b expected 0 0 00000",
                     tif.speaker, tif.note_active, tif.cur_index);
        end
    endtask

    task automatic test_random();
        logic exp_spk;
        for (int c = 0; c < 6000; c++) begin
            @(negedge clk);
`ifdef VOLUME_PWM_EN
            exp_spk = m_phase & (m_pwm <= tif.volume);
`else
            exp_spk = m_phase;
`endif
            vectors++;
            if (tif.speaker !== exp_spk) begin
                miscompares++; $display("FAIL rnd_speaker@%0d: got %b expected %b", c, tif.speaker, exp_spk);
            end
            vectors++;
            if (tif.note_active !== ~m_silent) begin
                miscompares++; $display("FAIL rnd_note_active@%0d: got %b expected %b", c, tif.note_active, ~m_silent);
            end
            vectors++;
            if (tif.cur_index !== m_cur) begin
                miscompares++; $display("FAIL rnd_cur_index@%0d: got %b expected %b", c, tif.cur_index, m_cur);
            end
            if (reset)                          reset = 1'b0;
            else if ($urandom_range(299) == 0)  reset = 1'b1;
            if ($urandom_range(39) == 0)        tif.note_index = 5'($urandom);
`ifdef VOLUME_PWM_EN
            if ($urandom_range(99) == 0)        tif.volume = 3'($urandom);
`endif
        end
    endtask

    initial begin
        rom_idx = 5'd0;
        test_reset();
        test_rom_decode();
        test_tone_start();
        test_reset_mid_tone();
        test_boundary_changes();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
